// File: rtl/dot_product_pkg.sv
// -----------------------------------------------------------------------------
// dot_product_pkg
// Shared definitions for the dot_product compute block.
//   dp_state_e : sequencer state encoding (IDLE, MULT, ACCUM, DONE)
//   DP_WIDTH   : element / product / sum width supported by the multiplier
//   DP_CNT_W() : width of the element counter for an N-element vector
// -----------------------------------------------------------------------------
package dot_product_pkg;

  // The elementwise multiplier is built for 32-bit lanes only.
  localparam int DP_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } dp_state_e;

  // Counter width able to index products 0..n-1. A width of at least one bit
  // is kept so that the counter remains a legal vector for any n.
  function automatic int DP_CNT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : dot_product_pkg

// File: rtl/dot_product_sequencer_mult.sv
// -----------------------------------------------------------------------------
// elementwise_multiplication
// Purely combinational lane-wise multiplier: vec_p[i] = low 32 bits of the
// unsigned product vec_a[i] * vec_b[i]. Element i is packed at [32*i +: 32].
// Ports
//   vec_a  in   32*N  first operand vector
//   vec_b  in   32*N  second operand vector
//   vec_p  out  32*N  truncated lane products
// -----------------------------------------------------------------------------
module elementwise_multiplication
  import dot_product_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [DP_WIDTH*N-1:0] vec_a,
  input  logic [DP_WIDTH*N-1:0] vec_b,
  output logic [DP_WIDTH*N-1:0] vec_p
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    // Assignment context is DP_WIDTH bits, so the product is the low half of
    // the full 64-bit result; any truncation is deliberately invisible here.
    assign vec_p[DP_WIDTH*i +: DP_WIDTH] =
      vec_a[DP_WIDTH*i +: DP_WIDTH] * vec_b[DP_WIDTH*i +: DP_WIDTH];
  end

endmodule : elementwise_multiplication

// File: rtl/dot_product_sequencer.sv
// -----------------------------------------------------------------------------
// dot_product_sequencer
// Computes one dot product per transaction. A vector pair is accepted on a
// valid/ready handshake, multiplied lane-wise in a single cycle, and the N
// registered products are then summed serially, one per cycle, into a
// WIDTH-bit accumulator that wraps modulo 2^WIDTH. The sum is offered on a
// valid/ready output and held until accepted.
//
// Timing: handshake in cycle T -> out_valid in cycle T+N+2; at most one
// result every N+3 cycles.
//
// Build option
//   DOT_OVF_DETECT_EN : adds the ovf port, a sticky flag raised whenever an
//                       accumulation step carries out of WIDTH bits. It is
//                       cleared when a new pair is accepted. Truncation of
//                       individual products is not detected.
//
// Ports
//   clk         in   1        clock, all state on the rising edge
//   rst_n       in   1        asynchronous active-low reset
//   clear       in   1        synchronous abort back to IDLE (wins over all)
//   in_valid    in   1        vector pair valid
//   in_ready    out  1        high in IDLE only
//   vector_a    in   WIDTH*N  element i at [WIDTH*i +: WIDTH]
//   vector_b    in   WIDTH*N  same packing as vector_a
//   out_valid   out  1        dot_result valid (DONE state)
//   out_ready   in   1        downstream accepts dot_result
//   dot_result  out  WIDTH    accumulator, meaningful while out_valid=1
//   busy        out  1        state != IDLE
//   ovf         out  1        only with DOT_OVF_DETECT_EN
// -----------------------------------------------------------------------------
module dot_product_sequencer
  import dot_product_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH*N-1:0] vector_a,
  input  logic [WIDTH*N-1:0] vector_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dot_result,
  output logic               busy
`ifdef DOT_OVF_DETECT_EN
  ,
  output logic               ovf
`endif
);

  localparam int CNT_W = DP_CNT_W(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The multiplier lanes are fixed at DP_WIDTH; any other WIDTH would
  // silently mis-slice the operand and product buses.
  if (WIDTH != DP_WIDTH) begin : g_width_check
    $error("dot_product_sequencer: WIDTH must equal DP_WIDTH (32)");
  end

  if (N < 2) begin : g_n_check
    $error("dot_product_sequencer: N must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  dp_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [WIDTH*N-1:0] op_a_q,  op_a_d;
  logic [WIDTH*N-1:0] op_b_q,  op_b_d;
  logic [WIDTH-1:0]   prod_q [N];
  logic [WIDTH-1:0]   prod_d [N];
`ifdef DOT_OVF_DETECT_EN
  logic               ovf_q,   ovf_d;
  // One extra bit so the carry out of each accumulation step is visible.
  logic [WIDTH:0]     sum;
`else
  logic [WIDTH-1:0]   sum;
`endif

  logic [WIDTH*N-1:0] mult_out;

  // ---------------------------------------------------------------------------
  // Lane multiplier, fed from the captured operands so its inputs are stable
  // for the whole MULT cycle regardless of what the source does.
  // ---------------------------------------------------------------------------
  elementwise_multiplication #(
    .N (N)
  ) u_mult (
    .vec_a (op_a_q),
    .vec_b (op_b_q),
    .vec_p (mult_out)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d starts as a copy of its _q so that no path through the
    // case statement leaves a variable unassigned (which would infer a latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    for (int i = 0; i < N; i++) begin
      prod_d[i] = prod_q[i];
    end
`ifdef DOT_OVF_DETECT_EN
    ovf_d = ovf_q;
    sum   = {1'b0, acc_q} + {1'b0, prod_q[cnt_q]};
`else
    sum   = acc_q + prod_q[cnt_q];
`endif

    if (clear) begin
      // Abort: accumulator and ovf keep their values, they are re-initialised
      // by the next transaction anyway.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_a_d  = vector_a;
            op_b_d  = vector_b;
            state_d = MULT;
`ifdef DOT_OVF_DETECT_EN
            ovf_d   = 1'b0;
`endif
          end
        end

        MULT: begin
          for (int i = 0; i < N; i++) begin
            prod_d[i] = mult_out[WIDTH*i +: WIDTH];
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end

        ACCUM: begin
          acc_d = sum[WIDTH-1:0];
`ifdef DOT_OVF_DETECT_EN
          ovf_d = ovf_q | sum[WIDTH];
`endif
          if (cnt_q == CNT_LAST) begin
            // Park the counter at zero rather than letting it step past N-1.
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      // NOTE: the product bank is an array of flops, not a RAM, so it is
      // reset like any other register to give a fully defined reset state.
      for (int i = 0; i < N; i++) begin
        prod_q[i] <= '0;
      end
`ifdef DOT_OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every flop sample the same
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      for (int i = 0; i < N; i++) begin
        prod_q[i] <= prod_d[i];
      end
`ifdef DOT_OVF_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded directly from flops, so they are glitch-free and change
  // only on a clock edge or on reset.
  // ---------------------------------------------------------------------------
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign dot_result = acc_q;
`ifdef DOT_OVF_DETECT_EN
  assign ovf        = ovf_q;
`endif

endmodule : dot_product_sequencer

// File: tb/tb_dot_product_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dot_product_sequencer
// Self-checking bench for dot_product_sequencer. A driver issues vector pairs
// and queues the expected result from an arithmetic reference model; a
// monitor checks every presented result against the queue head, including
// latency, hold-while-stalled and the return to IDLE. Directed cases cover
// reset, back-pressure, wrap/overflow, clear and asynchronous reset, followed
// by randomised traffic with random output stalls.
// -----------------------------------------------------------------------------
module tb_dot_product_sequencer;

  localparam int N     = 8;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] sum;
    bit               ovf;
    int               t_hs;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH*N-1:0] vector_a;
  logic [WIDTH*N-1:0] vector_b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   dot_result;
  logic               busy;
`ifdef DOT_OVF_DETECT_EN
  logic               ovf;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  bit   rand_stall = 1'b0;
  int   stall_cfg  = 0;

  dot_product_sequencer #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vector_a   (vector_a),
    .vector_b   (vector_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dot_result (dot_result),
    .busy       (busy)
`ifdef DOT_OVF_DETECT_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, test not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference: sum over i of (a_i*b_i mod 2^32), wrapped mod 2^32; overflow
  // if any running partial sum reaches 2^32.
  function automatic exp_t model(input logic [WIDTH*N-1:0] a,
                                 input logic [WIDTH*N-1:0] b);
    exp_t        e;
    logic [63:0] run;
    logic [63:0] p;
    run   = 64'd0;
    e.ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      p   = 64'(a[WIDTH*i +: WIDTH]) * 64'(b[WIDTH*i +: WIDTH]);
      p   = p & 64'h0000_0000_FFFF_FFFF;
      run = run + p;
      if (run >= 64'h1_0000_0000) begin
        e.ovf = 1'b1;
        run   = run - 64'h1_0000_0000;
      end
    end
    e.sum  = run[WIDTH-1:0];
    e.t_hs = 0;
    return e;
  endfunction

  function automatic logic [WIDTH*N-1:0] fill(input logic [WIDTH-1:0] v);
    logic [WIDTH*N-1:0] r;
    for (int i = 0; i < N; i++) r[WIDTH*i +: WIDTH] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_elem();
    case ($urandom_range(0, 2))
      0:       return WIDTH'($urandom_range(0, 15));
      1:       return WIDTH'($urandom);
      default: return 32'hFFFF_FFFF - WIDTH'($urandom_range(0, 255));
    endcase
  endfunction

  // Present a pair and hold it until accepted. When push=1 the model result
  // is queued at the handshake cycle t.
  task automatic send(input logic [WIDTH*N-1:0] a, input logic [WIDTH*N-1:0] b,
                      input bit push, output int t);
    exp_t e;
    int   waited;
    @(posedge clk); #1;
    in_valid = 1'b1;
    vector_a = a;
    vector_b = b;
    waited   = 0;
    t        = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    t = cyc;
    if (push) begin
      e      = model(a, b);
      e.t_hs = t;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        check("drain_timeout_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic wait_cycle(input int target);
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (cyc != target && guard < 100);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'd1);
    check({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_dot_result"}, 64'(dot_result), 64'd0);
`ifdef DOT_OVF_DETECT_EN
    check({tag, "_ovf"},        64'(ovf),        64'd0);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Output back-pressure: stall_cfg (or a random 0..3) cycles of out_ready=0
  // at the start of each DONE period, then accept.
  // ---------------------------------------------------------------------------
  initial begin
    int stall_left = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready  = 1'b0;
        stall_left = rand_stall ? int'($urandom_range(0, 3)) : stall_cfg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    bit   prev_v   = 1'b0;
    bit   chk_idle = 1'b0;
    int   rise     = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_idle) begin
        check("after_accept_busy",      64'(busy),      64'd0);
        check("after_accept_in_ready",  64'(in_ready),  64'd1);
        check("after_accept_out_valid", 64'(out_valid), 64'd0);
        chk_idle = 1'b0;
      end
      if (out_valid) begin
        if (!prev_v) rise = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1, required 0 (cycle %0d)", cyc);
        end else begin
          check("dot_result",        64'(dot_result), 64'(exp_q[0].sum));
          check("in_ready_while_done", 64'(in_ready), 64'd0);
`ifdef DOT_OVF_DETECT_EN
          check("ovf",               64'(ovf),        64'(exp_q[0].ovf));
`endif
          if (out_ready) begin
            e = exp_q.pop_front();
            check("latency", 64'(rise - e.t_hs), 64'(N + 2));
            chk_idle = 1'b1;
          end
        end
      end
      prev_v = out_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [WIDTH*N-1:0] a, b;
    int t;

    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    vector_a = '0;
    vector_b = '0;

    // 1. Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("post_reset_idle");

    // 2. a = 1..8, b = 1, immediate accept -> 36
    for (int i = 0; i < N; i++) a[WIDTH*i +: WIDTH] = WIDTH'(i + 1);
    send(a, fill(32'd1), 1'b1, t);
    drain();

    // 3. Held result under 5 cycles of back-pressure -> 48
    stall_cfg = 5;
    send(fill(32'd2), fill(32'd3), 1'b1, t);
    drain();
    stall_cfg = 0;

    // 4. Wrap / overflow, then a clean sum
    send(fill(32'hFFFF_FFFF), fill(32'd1), 1'b1, t);
    drain();
    send(fill(32'd1), fill(32'd1), 1'b1, t);
    drain();

    // 5. clear during ACCUM at cnt=3 (cycle T+5), then a fresh pair
    send(fill(32'd7), fill(32'd9), 1'b0, t);
    wait_cycle(t + 5);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_busy",      64'(busy),      64'd0);
    check("clear_in_ready",  64'(in_ready),  64'd1);
    check("clear_out_valid", 64'(out_valid), 64'd0);
    repeat (N + 4) @(negedge clk);
    send(fill(32'd1), fill(32'd1), 1'b1, t);
    drain();

    // 6. Asynchronous reset in the middle of ACCUM
    send(fill(32'd5), fill(32'd1), 1'b0, t);
    wait_cycle(t + 5);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    for (int i = 0; i < N; i++) a[WIDTH*i +: WIDTH] = WIDTH'(3 * i + 2);
    send(a, fill(32'd4), 1'b1, t);
    drain();

    // 7. Randomised traffic with random back-pressure
    rand_stall = 1'b1;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < N; i++) begin
        a[WIDTH*i +: WIDTH] = rand_elem();
        b[WIDTH*i +: WIDTH] = rand_elem();
      end
      send(a, b, 1'b1, t);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_dot_product_sequencer
